// File: rtl/mem_access_unit_if.sv
// Bundles for mem_access_unit: op side (execute-stage request, one-shot response)
// and data-memory request/ack bus. Unit uses op.slave and mem.master.
interface mau_op_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_load_type;
  logic        rsp_misalign;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_load_type, rsp_misalign, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data,
    output rsp_load_type, rsp_misalign, rsp_err
  );
endinterface

interface mau_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bus sequencer: alignment check, word bus request/ack, timeout.
// Ports: clk, rst (sync, high), op (mau_op_if.slave), mem (mau_mem_if.master).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  mau_op_if.slave   op,
  mau_mem_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        accept;
  logic        mis;
  logic        ack_hit;
  logic        tmo;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [31:0] rd_sh;
  logic [31:0] rd_ld;

  assign op.req_ready = (state == S_IDLE);
  assign op.rsp_valid = (state == S_RESP);
  assign accept  = (state == S_IDLE) && op.req_valid;
  assign ack_hit = (state == S_BUS) && mem.mem_ack;
  assign tmo     = (state == S_BUS) && !mem.mem_ack
                && (cnt == 8'(TIMEOUT_CYCLES - 1));

  // Alignment and store lane steering
  always_comb begin
    mis   = 1'b1;
    be_nx = 4'b1111;
    wd_nx = op.req_wdata;
    unique case (1'b1)
      op.req_funct3[1:0] == 2'b00: begin
        mis   = 1'b0;
        be_nx = 4'b0001 << op.req_addr[1:0];
        wd_nx = {4{op.req_wdata[7:0]}};
      end
      op.req_funct3[1:0] == 2'b01: begin
        mis   = op.req_addr[0];
        be_nx = 4'b0011 << op.req_addr[1:0];
        wd_nx = {2{op.req_wdata[15:0]}};
      end
      op.req_funct3[1:0] == 2'b10: begin
        mis = |op.req_addr[1:0];
      end
      default: ;
    endcase
    if (!op.req_we) begin
      be_nx = 4'b1111;
      wd_nx = '0;
    end
  end

  // Shift the addressed bytes to bit 0; bytes above the access size are zeroed
  always_comb begin
    rd_sh = mem.mem_rdata >> {off_q, 3'b000};
    rd_ld = rd_sh;
    unique case (1'b1)
      f3_q[1:0] == 2'b00: rd_ld = {24'd0, rd_sh[7:0]};
      f3_q[1:0] == 2'b01: rd_ld = {16'd0, rd_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = mis ? S_RESP : S_BUS;
      S_BUS:  if (ack_hit || tmo) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt               <= '0;
      we_q              <= 1'b0;
      f3_q              <= '0;
      off_q             <= '0;
      mem.mem_req       <= 1'b0;
      mem.mem_we        <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_wdata     <= '0;
      mem.mem_be        <= '0;
      op.rsp_data       <= '0;
      op.rsp_load_type  <= '0;
      op.rsp_misalign   <= 1'b0;
      op.rsp_err        <= 1'b0;
    end else begin
      if (accept) begin
        we_q  <= op.req_we;
        f3_q  <= op.req_funct3;
        off_q <= op.req_addr[1:0];
        if (mis) begin
          op.rsp_data      <= '0;
          op.rsp_load_type <= op.req_funct3;
          op.rsp_misalign  <= 1'b1;
          op.rsp_err       <= 1'b0;
        end else begin
          cnt           <= '0;
          mem.mem_req   <= 1'b1;
          mem.mem_we    <= op.req_we;
          mem.mem_addr  <= {op.req_addr[31:2], 2'b00};
          mem.mem_wdata <= wd_nx;
          mem.mem_be    <= be_nx;
        end
      end
      if (ack_hit) begin
        cnt              <= '0;
        mem.mem_req      <= 1'b0;
        op.rsp_data      <= we_q ? '0 : rd_ld;
        op.rsp_load_type <= f3_q;
        op.rsp_misalign  <= 1'b0;
        op.rsp_err       <= 1'b0;
      end else if (tmo) begin
        cnt              <= '0;
        mem.mem_req      <= 1'b0;
        op.rsp_data      <= '0;
        op.rsp_load_type <= f3_q;
        op.rsp_misalign  <= 1'b0;
        op.rsp_err       <= 1'b1;
      end else if (state == S_BUS) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops, bus and response
// expectations queued at issue, checked by independent monitors.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mau_op_if  op();
  mau_mem_if mem();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .op  (op),
    .mem (mem)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  lt;
    logic        mis;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  rsp_t        rsp_q[$];
  bus_t        bus_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          mem_delay = 0;
  logic [31:0] mem_rd = '0;
  logic        spur = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  task automatic push_rsp(logic [31:0] d, logic [2:0] lt, logic mis, logic err);
    rsp_t e;
    e.data = d;
    e.lt   = lt;
    e.mis  = mis;
    e.err  = err;
    rsp_q.push_back(e);
  endtask

  task automatic push_bus(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    bus_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.be    = be;
    bus_q.push_back(e);
  endtask

  // Memory model: acks after mem_delay waited BUS cycles (-1 = never)
  initial begin
    int wc;
    wc = 0;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem.mem_req) begin
        if (wc == mem_delay) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = mem_rd;
          wc = 0;
        end else begin
          mem.mem_ack   = 1'b0;
          mem.mem_rdata = 32'h0BAD0BAD;
          wc++;
        end
      end else begin
        mem.mem_ack   = spur;
        mem.mem_rdata = 32'hDEADBEEF;
        wc = 0;
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (op.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 want no response");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_data", op.rsp_data, e.data);
          chk("rsp_load_type", 32'(op.rsp_load_type), 32'(e.lt));
          chk("rsp_misalign", 32'(op.rsp_misalign), 32'(e.mis));
          chk("rsp_err", 32'(op.rsp_err), 32'(e.err));
        end
      end
    end
  end

  // Bus monitor: checks each new request on its first cycle
  initial begin
    bus_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.mem_req && !prev) begin
        if (bus_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL bus_unexpected: got mem_req=1 want no request");
        end else begin
          e = bus_q.pop_front();
          chk("mem_we", 32'(mem.mem_we), 32'(e.we));
          chk("mem_addr", mem.mem_addr, e.addr);
          chk("mem_be", 32'(mem.mem_be), 32'(e.be));
          if (e.we) chk("mem_wdata", mem.mem_wdata, e.wdata);
        end
      end
      prev = mem.mem_req;
    end
  end

  // Called at a negedge; returns at the negedge where rsp_valid is seen
  task automatic run_op(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          exp_lat,
    input int          exp_req,
    input int          exp_wait,
    input string       tag
  );
    int waits;
    int lat;
    int reqc;
    waits = 0;
    lat   = 0;
    reqc  = 0;
    op.req_valid  = 1'b1;
    op.req_we     = we;
    op.req_funct3 = f3;
    op.req_addr   = addr;
    op.req_wdata  = wd;
    while (!op.req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, "_wait"}, 32'(waits), 32'(exp_wait));
    @(posedge clk);
    do begin
      @(negedge clk);
      op.req_valid = 1'b0;
      lat++;
      if (mem.mem_req) reqc++;
    end while (!op.rsp_valid && lat < 300);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_req"}, 32'(reqc), 32'(exp_req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    op.req_valid  = 1'b0;
    op.req_we     = 1'b0;
    op.req_funct3 = '0;
    op.req_addr   = '0;
    op.req_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(op.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(op.rsp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem.mem_be), 32'd0);
    chk("rst_rsp_data", op.rsp_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LB from byte 3
    mem_delay = 0;
    mem_rd = 32'hAABBCCDD;
    push_bus(1'b0, 32'h1000, 32'h0, 4'b1111);
    push_rsp(32'h000000AA, 3'b000, 1'b0, 1'b0);
    run_op(1'b0, 3'b000, 32'h1003, 32'h0, 2, 1, 0, "lb");

    // SH to upper half; store response data is zero
    mem_rd = 32'hFFFFFFFF;
    push_bus(1'b1, 32'h0100, 32'h12341234, 4'b1100);
    push_rsp(32'h0, 3'b001, 1'b0, 1'b0);
    run_op(1'b1, 3'b001, 32'h0102, 32'h00001234, 2, 1, 1, "sh");

    // Misaligned / illegal size: no bus request
    push_rsp(32'h0, 3'b010, 1'b1, 1'b0);
    run_op(1'b0, 3'b010, 32'h0006, 32'h0, 1, 0, 1, "lw_mis");
    push_rsp(32'h0, 3'b001, 1'b1, 1'b0);
    run_op(1'b0, 3'b001, 32'h0001, 32'h0, 1, 0, 1, "lh_mis");
    push_rsp(32'h0, 3'b011, 1'b1, 1'b0);
    run_op(1'b0, 3'b011, 32'h0010, 32'h0, 1, 0, 1, "f3_011");

    // Aligned word and half loads, word store
    mem_rd = 32'h12345678;
    push_bus(1'b0, 32'h0008, 32'h0, 4'b1111);
    push_rsp(32'h12345678, 3'b010, 1'b0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0008, 32'h0, 2, 1, 1, "lw");
    mem_rd = 32'hAABBCCDD;
    push_bus(1'b0, 32'h0000, 32'h0, 4'b1111);
    push_rsp(32'h0000AABB, 3'b001, 1'b0, 1'b0);
    run_op(1'b0, 3'b001, 32'h0002, 32'h0, 2, 1, 1, "lh_hi");
    push_bus(1'b1, 32'h0020, 32'hCAFEBABE, 4'b1111);
    push_rsp(32'h0, 3'b010, 1'b0, 1'b0);
    run_op(1'b1, 3'b010, 32'h0020, 32'hCAFEBABE, 2, 1, 1, "sw");

    // Timeout after 4 BUS cycles, then a normal op
    mem_delay = -1;
    push_bus(1'b0, 32'h0040, 32'h0, 4'b1111);
    push_rsp(32'h0, 3'b010, 1'b0, 1'b1);
    run_op(1'b0, 3'b010, 32'h0040, 32'h0, 5, 4, 1, "tmo");
    mem_delay = 0;
    mem_rd = 32'hCAFEF00D;
    push_bus(1'b0, 32'h0044, 32'h0, 4'b1111);
    push_rsp(32'hCAFEF00D, 3'b010, 1'b0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0044, 32'h0, 2, 1, 1, "post_tmo");

    // LHU with slow ack, aborted by reset; later stray ack ignored
    mem_delay = 3;
    mem_rd = 32'h55667788;
    push_bus(1'b0, 32'h0000, 32'h0, 4'b1111);
    op.req_valid  = 1'b1;
    op.req_we     = 1'b0;
    op.req_funct3 = 3'b101;
    op.req_addr   = 32'h0002;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    op.req_valid = 1'b0;
    chk("abort_req_hi", 32'(mem.mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", 32'(mem.mem_req), 32'd0);
    chk("abort_ready", 32'(op.req_ready), 32'd1);
    chk("abort_rsp_data", op.rsp_data, 32'd0);
    rst = 1'b0;
    mem_delay = 0;
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    chk("spur_rsp_valid", 32'(op.rsp_valid), 32'd0);
    chk("spur_ready", 32'(op.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("spur_rsp_valid2", 32'(op.rsp_valid), 32'd0);
    chk("spur_mem_req", 32'(mem.mem_req), 32'd0);

    // Back-to-back SB then LBU
    push_bus(1'b1, 32'h0000, 32'h5A5A5A5A, 4'b1000);
    push_rsp(32'h0, 3'b000, 1'b0, 1'b0);
    run_op(1'b1, 3'b000, 32'h0003, 32'h0000005A, 2, 1, 0, "sb");
    chk("resp_ready", 32'(op.req_ready), 32'd0);
    mem_rd = 32'h11223344;
    push_bus(1'b0, 32'h0000, 32'h0, 4'b1111);
    push_rsp(32'h00000022, 3'b100, 1'b0, 1'b0);
    run_op(1'b0, 3'b100, 32'h0002, 32'h0, 2, 1, 1, "lbu");
    @(negedge clk);
    chk("hold_rsp_valid", 32'(op.rsp_valid), 32'd0);
    chk("hold_rsp_data", op.rsp_data, 32'h00000022);
    chk("hold_load_type", 32'(op.rsp_load_type), 32'd4);

    repeat (3) @(negedge clk);
    chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
